// File: rtl/sa_cache_wb.sv
// N-way set-associative write-back/write-allocate cache with true-LRU replacement.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module sa_cache_wb #(
  parameter int ADDR_W     = 20,
  parameter int WORD_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_req_we,
  input  logic [ADDR_W-1:0]         cpu_req_addr,
  input  logic [WORD_W-1:0]         cpu_req_wdata,
  input  logic [WORD_W/8-1:0]       cpu_req_be,
  output logic                      cpu_resp_valid,
  output logic [WORD_W-1:0]         cpu_resp_rdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [LINE_BYTES*8-1:0]   mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0]   mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BE_W   = WORD_W / 8;
  localparam int BO_W   = $clog2(BE_W);
  localparam int WPL    = LINE_W / WORD_W;
  localparam int WSEL_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL_REQ, FILL_WAIT, RESPOND} state_t;

  state_t              state;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [WORD_W-1:0]   req_wdata;
  logic [BE_W-1:0]     req_be;
  logic [WAY_W-1:0]    vic_way;

  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WSEL_W-1:0]   wsel;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    lru_way;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    acc_way;
  logic [WAY_W-1:0]    acc_age;
  logic [LINE_W-1:0]   base_line;
  logic [LINE_W-1:0]   new_line;
  logic [WORD_W-1:0]   old_word;
  logic [WORD_W-1:0]   merged_word;
  logic                line_we;
  logic                fill_done;
  logic                lru_en;

  assign idx  = req_addr[OFF_W +: IDX_W];
  assign tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign wsel = WSEL_W'(req_addr[OFF_W-1:0] >> BO_W);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      // Ages are a permutation, so the oldest way is the one holding WAYS-1.
      if (age_q[idx][w] == WAY_W'(WAYS - 1))
        lru_way = WAY_W'(w);
    end
    victim = inv_found ? inv_way : lru_way;
  end

  assign fill_done = (state == FILL_WAIT) && mem_resp_valid;
  assign acc_way   = (state == FILL_WAIT) ? vic_way : hit_way;
  assign acc_age   = age_q[idx][acc_way];
  assign lru_en    = ((state == LOOKUP) && hit) || fill_done;
  assign line_we   = ((state == LOOKUP) && hit && req_we) || fill_done;

  // Hit writes and write-allocate fills share one byte-merge path.
  always_comb begin
    base_line   = (state == FILL_WAIT) ? mem_resp_rdata : data_q[idx][acc_way];
    old_word    = base_line[int'(wsel) * WORD_W +: WORD_W];
    merged_word = old_word;
    for (int unsigned b = 0; b < BE_W; b++)
      if (req_be[b]) merged_word[b*8 +: 8] = req_wdata[b*8 +: 8];
    new_line = base_line;
    if (req_we) new_line[int'(wsel) * WORD_W +: WORD_W] = merged_word;
  end

  always_ff @(posedge clk) begin
    if (line_we) data_q[idx][acc_way] <= new_line;
    if (fill_done) tag_q[idx][vic_way] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_be         <= '0;
      vic_way        <= '0;
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
`ifdef CACHE_STATS_EN
      hit_count      <= '0;
      miss_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            req_we        <= cpu_req_we;
            req_addr      <= cpu_req_addr;
            req_wdata     <= cpu_req_wdata;
            req_be        <= cpu_req_be;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end else begin
            cpu_req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we) dirty_q[idx][hit_way] <= 1'b1;
            cpu_resp_rdata <= req_we ? '0 : old_word;
            cpu_resp_valid <= 1'b1;
            state          <= RESPOND;
`ifdef CACHE_STATS_EN
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            vic_way       <= victim;
            mem_req_valid <= 1'b1;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              mem_req_we    <= 1'b1;
              mem_req_addr  <= {tag_q[idx][victim], idx, OFF_W'(0)};
              mem_req_wdata <= data_q[idx][victim];
              state         <= EVICT;
            end else begin
              mem_req_we    <= 1'b0;
              mem_req_addr  <= {tag, idx, OFF_W'(0)};
              mem_req_wdata <= '0;
              state         <= FILL_REQ;
            end
`ifdef CACHE_STATS_EN
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        EVICT: begin
          if (mem_req_ready) begin
            dirty_q[idx][vic_way] <= 1'b0;
            mem_req_we            <= 1'b0;
            mem_req_addr          <= {tag, idx, OFF_W'(0)};
            mem_req_wdata         <= '0;
            state                 <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx][vic_way] <= 1'b1;
            dirty_q[idx][vic_way] <= req_we;
            cpu_resp_rdata        <= req_we ? '0 : old_word;
            cpu_resp_valid        <= 1'b1;
            state                 <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_resp_valid <= 1'b0;
          cpu_resp_rdata <= '0;
          cpu_req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (lru_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way)
            age_q[idx][w] <= '0;
          else if (age_q[idx][w] < acc_age)
            age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_cache_wb.sv
// Directed bench for sa_cache_wb: line-granular memory model with optional
// request stalling and held fill responses; CACHE_STATS_EN adds counter checks.
module tb_sa_cache_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_ready;
  logic         cpu_req_we = 1'b0;
  logic [19:0]  cpu_req_addr = '0;
  logic [31:0]  cpu_req_wdata = '0;
  logic [3:0]   cpu_req_be = '0;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_we;
  logic [19:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  sa_cache_wb #(.ADDR_W(20), .WORD_W(32), .LINE_BYTES(16), .SETS(32), .WAYS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing store: 0x00040 has a hand-picked line, others encode address and word index.
  function automatic logic [127:0] line_for(input logic [19:0] a);
    logic [127:0] l;
    if (a == 20'h00040) return {32'h33333333, 32'h22222222, 32'hAAAAAAAA, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = {a[19:4], 16'(i)};
    return l;
  endfunction

  int           stall_cfg = 0;
  logic         hold_resp = 1'b0;
  int           fill_cnt = 0, wb_cnt = 0, seq = 0, fill_seq = 0, wb_seq = 0;
  logic [19:0]  last_fill_addr = '0, last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  logic         seen = 1'b0, pend_fill = 1'b0, cap_we = 1'b0;
  int           wait_ctr = 0;
  logic [19:0]  cap_addr = '0, pend_addr = '0;
  logic [127:0] cap_wdata = '0;
  logic [149:0] snap = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      pend_fill      = 1'b0;
      seen           = 1'b0;
    end else begin
      mem_resp_valid = 1'b0;
      if (pend_fill && !hold_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = line_for(pend_addr);
        pend_fill      = 1'b0;
      end
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        seq++;
        if (cap_we) begin
          wb_cnt++; wb_seq = seq; last_wb_addr = cap_addr; last_wb_data = cap_wdata;
        end else begin
          fill_cnt++; fill_seq = seq; last_fill_addr = cap_addr;
          pend_fill = 1'b1; pend_addr = cap_addr;
        end
      end else if (mem_req_valid) begin
        if (!seen) begin
          seen = 1'b1; wait_ctr = 0;
          snap = {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
        end
        if (wait_ctr > 0)
          check("mem_req_hold", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, snap);
        if (wait_ctr < stall_cfg) begin
          wait_ctr++;
        end else begin
          mem_req_ready = 1'b1;
          cap_we = mem_req_we; cap_addr = mem_req_addr; cap_wdata = mem_req_wdata;
          seen = 1'b0;
        end
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [19:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr;
    cpu_req_wdata = wd; cpu_req_be = be;
    n = 0;
    while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_req_ready) check("req_ready_timeout", cpu_req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 300) begin @(negedge clk); lat++; end
    if (!cpu_resp_valid) check("resp_timeout", cpu_resp_valid, 1'b1);
    rd = cpu_resp_rdata;
  endtask

  logic [31:0] rd;
  int          lat, f0, w0, n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_req_we,
                            mem_req_addr, cpu_resp_rdata, mem_req_wdata}, '0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", cpu_req_ready, 1'b1);

    // Cold read miss then hit on 0x00040 (set 4, tag A=0).
    f0 = fill_cnt;
    cpu_op(1'b0, 20'h00040, '0, '0, rd, lat);
    check("miss_rdata", rd, 32'hDEADBEEF);
    check("miss_fill_addr", last_fill_addr, 20'h00040);
    check("miss_fill_cnt", fill_cnt - f0, 1);
    f0 = fill_cnt;
    cpu_op(1'b0, 20'h00040, '0, '0, rd, lat);
    check("hit_rdata", rd, 32'hDEADBEEF);
    check("hit_latency", lat, 2);
    check("hit_no_mem", fill_cnt - f0, 0);

    // Byte-enabled write hit, then read back the merged word.
    cpu_op(1'b1, 20'h00044, 32'h11223344, 4'b0011, rd, lat);
    check("write_resp_rdata", rd, 32'h0);
    check("write_hit_latency", lat, 2);
    cpu_op(1'b0, 20'h00044, '0, '0, rd, lat);
    check("merged_rdata", rd, 32'hAAAA3344);

    // LRU: fill B, touch A, miss C evicts B (clean), A still hits, B misses.
    f0 = fill_cnt; w0 = wb_cnt;
    cpu_op(1'b0, 20'h00240, '0, '0, rd, lat);
    check("fill_b_rdata", rd, 32'h00240000);
    cpu_op(1'b0, 20'h00048, '0, '0, rd, lat);
    check("touch_a_rdata", rd, 32'h22222222);
    check("touch_a_hit", fill_cnt - f0, 1);
    cpu_op(1'b0, 20'h00440, '0, '0, rd, lat);
    check("fill_c_rdata", rd, 32'h00440000);
    check("fill_c_addr", last_fill_addr, 20'h00440);
    check("clean_evict_no_wb", wb_cnt - w0, 0);
    f0 = fill_cnt;
    cpu_op(1'b0, 20'h00040, '0, '0, rd, lat);
    check("a_still_hits", fill_cnt - f0, 0);
    check("a_rdata", rd, 32'hDEADBEEF);
    cpu_op(1'b0, 20'h00240, '0, '0, rd, lat);
    check("b_was_evicted", fill_cnt - f0, 1);

    // Dirty A is now LRU: write-back under a 5-cycle ready stall, then fill.
    f0 = fill_cnt; w0 = wb_cnt;
    stall_cfg = 5;
    cpu_op(1'b0, 20'h00640, '0, '0, rd, lat);
    stall_cfg = 0;
    check("wb_cnt", wb_cnt - w0, 1);
    check("wb_addr", last_wb_addr, 20'h00040);
    check("wb_data", last_wb_data, {32'h33333333, 32'h22222222, 32'hAAAA3344, 32'hDEADBEEF});
    check("wb_before_fill", wb_seq < fill_seq, 1'b1);
    check("fill_after_wb_addr", last_fill_addr, 20'h00640);
    check("dirty_miss_rdata", rd, 32'h00640000);

    // Write miss allocates and merges into the fill line.
    cpu_op(1'b1, 20'h00A44, 32'h55667788, 4'b1100, rd, lat);
    check("write_miss_resp", rd, 32'h0);
    f0 = fill_cnt;
    cpu_op(1'b0, 20'h00A44, '0, '0, rd, lat);
    check("write_alloc_rdata", rd, 32'h55660001);
    check("write_alloc_hit", fill_cnt - f0, 0);

    // Reset while the fill response is outstanding.
    hold_resp = 1'b1;
    f0 = fill_cnt;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 20'h00840; cpu_req_be = '0;
    n = 0;
    while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (fill_cnt == f0 && n < 50) begin @(negedge clk); n++; end
    check("fill_req_seen", fill_cnt - f0, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_outputs", {mem_req_valid, cpu_resp_valid, cpu_req_ready}, 3'b000);
    repeat (2) @(negedge clk);
    hold_resp = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    f0 = fill_cnt;
    cpu_op(1'b0, 20'h00840, '0, '0, rd, lat);
    check("post_reset_miss", fill_cnt - f0, 1);
    check("post_reset_rdata", rd, 32'h00840000);
    cpu_op(1'b0, 20'h00840, '0, '0, rd, lat);
    check("hit_w0", rd, 32'h00840000);
    cpu_op(1'b0, 20'h00844, '0, '0, rd, lat);
    check("hit_w1", rd, 32'h00840001);
    cpu_op(1'b0, 20'h00848, '0, '0, rd, lat);
    check("hit_w2", rd, 32'h00840002);
    cpu_op(1'b0, 20'h00040, '0, '0, rd, lat);
    check("refill_a_rdata", rd, 32'hDEADBEEF);
    check("refill_a_cnt", fill_cnt - f0, 2);
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 32'd3);
    check("miss_count", miss_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
